alu_ctrl_pipe: RTL
==================

ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 SHALL have parameter OP_W, default 4, width of op output (legal range 4..8).
REQ-002 SHALL have parameter MD_CYCLES, default 4, mult/div issue latency in cycles (legal range 2..16).
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  decode request valid.
REQ-006 in_ready  out  1  block can accept request this cycle.
REQ-007 alu_op  in  3  class: 000 I-type, 001 R-type, 010 branch, 100 load/store.
REQ-008 opcode  in  6  instruction opcode; funct  in  6  R-type function field.
REQ-009 out_valid  out  1  op/illegal/md_op valid; out_ready  in  1  consumer accepts result.
REQ-010 op  out  OP_W  ALU operation code, zero-extended to OP_W.
REQ-011 illegal  out  1  request decoded to no legal operation.
REQ-012 md_op  out  1  result is a multi-cycle (mult/div) operation; md_busy  out  1  multi-cycle countdown running.

Function
REQ-013 Encoding SHALL be: and 0, or 1, xor 2, nor 3, add 5, sub 6, slt 7, srl 8, sll 9, sra 10, mult 11, div 12; illegal op = all ones.
REQ-014 alu_op 100 -> add; 010 -> sub; 000 uses opcode: 001000 add, 001100 and, 001101 or, 001010 slti->slt, 001110 xor.
REQ-015 alu_op 001 uses funct: 100100 and, 100101 or, 100110 xor, 100111 nor, 100000 add, 100010 sub, 101010 slt, 000010 srl, 000000 sll, 000011 sra, 011000 mult, 011010 div.
REQ-016 Any unlisted opcode/funct, or alu_op in {011,101,110,111}, SHALL produce op all ones, illegal 1, md_op 0, with normal 1-cycle handshake (never a held prior value).
REQ-017 FSM states: IDLE (output empty), HOLD (output valid), MD (countdown).
REQ-018 in_ready = 1 in IDLE; = out_ready in HOLD; = 0 in MD.
REQ-019 Request accepted when in_valid && in_ready; single-cycle op accepted at edge T SHALL show out_valid=1 with decoded op after edge T (latency 1).
REQ-020 mult/div accepted at edge T SHALL enter MD, load counter with MD_CYCLES-1, md_busy=1, out_valid=0; counter decrements per edge; at 0 -> HOLD, out_valid=1, md_op=1; total latency MD_CYCLES edges.
REQ-021 HOLD with out_ready=1 and no new accept -> IDLE, out_valid=0; with out_ready=1 and new accept -> back-to-back reload (HOLD or MD), no bubble.
REQ-022 HOLD with out_ready=0: op, illegal, md_op SHALL remain stable, in_ready=0.
REQ-023 in_valid, alu_op, opcode, funct SHALL be ignored while not accepted, including during MD.
REQ-024 Counter SHALL be $clog2(MD_CYCLES)+1 bits; no wrap below 0.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, counter 0, out_valid 0, op 0, illegal 0, md_op 0, md_busy 0; in_ready 1 after deassertion.
REQ-026 Reset during MD or HOLD SHALL discard the in-flight request without emitting it.
REQ-027 First accept allowed on first rising edge with rst_n=1.

Configuration
REQ-028 Macro ALU_CTRL_MULDIV_EN defined: mult/div decode, MD state, counter and md_busy per REQ-020.
REQ-029 Macro ALU_CTRL_MULDIV_EN undefined: funct 011000/011010 SHALL decode illegal per REQ-016; MD state and counter absent; md_op, md_busy tied 0; MD_CYCLES unused.

Verification
REQ-030 Reset, then alu_op=001 funct=100010 in_valid=1 out_ready=1 -> next cycle out_valid=1 op=6 illegal=0.
REQ-031 Stream alu_op=000 opcode 001100,001101,001110 in consecutive cycles, out_ready=1 -> op 0,1,2 on consecutive cycles, in_ready stays 1.
REQ-032 alu_op=001 funct=011000, MD_CYCLES=4, macro on -> md_busy=1 for 3 cycles, in_ready=0, out_valid=1 op=11 md_op=1 exactly 4 edges after accept; macro off -> op=4'hF illegal=1 after 1 edge.
REQ-033 alu_op=111 then out_ready=0 for 5 cycles -> op=4'hF illegal=1 held stable, in_ready=0, new in_valid ignored until out_ready=1.
REQ-034 Accept div, assert rst_n=0 at countdown 2 -> outputs 0 immediately, no result emitted after release.

Source files
------------

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: ALU control decoder with valid/ready handshake and optional multi-cycle mult/div path.
// Define ALU_CTRL_MULDIV_EN to enable mult/div decode, the MD countdown state and md_busy.
module alu_ctrl_pipe #(
  parameter int OP_W      = 4,
  parameter int MD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] op,
  output logic            illegal,
  output logic            md_op,
  output logic            md_busy
);
  if (OP_W < 4 || OP_W > 8 || MD_CYCLES < 2 || MD_CYCLES > 16) begin : g_bad_param
    $error("alu_ctrl_pipe: parameter out of range");
  end
  localparam int CW = $clog2(MD_CYCLES) + 1;
  logic [3:0]      code;
  logic            ill;
  logic            is_md;
  logic            acc;
  logic [OP_W-1:0] dec_op;
  always_comb begin
    code  = 4'd0;
    ill   = 1'b0;
    is_md = 1'b0;
    case (alu_op)
      3'b100: code = 4'd5;
      3'b010: code = 4'd6;
      3'b000:
        case (opcode)
          6'b001000: code = 4'd5;
          6'b001100: code = 4'd0;
          6'b001101: code = 4'd1;
          6'b001010: code = 4'd7;
          6'b001110: code = 4'd2;
          default:   ill  = 1'b1;
        endcase
      3'b001:
        case (funct)
          6'b100100: code = 4'd0;
          6'b100101: code = 4'd1;
          6'b100110: code = 4'd2;
          6'b100111: code = 4'd3;
          6'b100000: code = 4'd5;
          6'b100010: code = 4'd6;
          6'b101010: code = 4'd7;
          6'b000010: code = 4'd8;
          6'b000000: code = 4'd9;
          6'b000011: code = 4'd10;
`ifdef ALU_CTRL_MULDIV_EN
          6'b011000: begin code = 4'd11; is_md = 1'b1; end
          6'b011010: begin code = 4'd12; is_md = 1'b1; end
`endif
          default:   ill  = 1'b1;
        endcase
      default: ill = 1'b1;
    endcase
  end
  assign dec_op = ill ? '1 : OP_W'(code);
  assign acc    = in_valid && in_ready;
`ifdef ALU_CTRL_MULDIV_EN
  typedef enum logic [1:0] {IDLE, HOLD, MD} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  assign in_ready = (state == IDLE) ? 1'b1 : (state == HOLD) ? out_ready : 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      op        <= '0;
      illegal   <= 1'b0;
      md_op     <= 1'b0;
      md_busy   <= 1'b0;
    end else if (acc) begin
      op      <= dec_op;
      illegal <= ill;
      md_op   <= is_md;
      if (is_md) begin
        state     <= MD;
        cnt       <= CW'(MD_CYCLES - 1);
        md_busy   <= 1'b1;
        out_valid <= 1'b0;
      end else begin
        state     <= HOLD;
        out_valid <= 1'b1;
      end
    end else if (state == HOLD && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else if (state == MD) begin
      // md_busy drops as the counter reaches zero; the result appears one edge later
      if (cnt == '0) begin
        state     <= HOLD;
        out_valid <= 1'b1;
      end else begin
        cnt     <= cnt - CW'(1);
        md_busy <= (cnt != CW'(1));
      end
    end
  end
`else
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  assign in_ready = (state == IDLE) || out_ready;
  assign md_op    = 1'b0;
  assign md_busy  = 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      op        <= '0;
      illegal   <= 1'b0;
    end else if (acc) begin
      state     <= HOLD;
      out_valid <= 1'b1;
      op        <= dec_op;
      illegal   <= ill;
    end else if (state == HOLD && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end
`endif
endmodule
